// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MADDU = 3'd3;
    localparam logic [2:0] OP_MSUB  = 3'd4;
    localparam logic [2:0] OP_MSUBU = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_DIVU  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    // Even encodings are the signed flavours.
    function automatic logic is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

    function automatic logic is_acc(input logic [2:0] op);
        return (op >= OP_MADD) && (op <= OP_MSUBU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             fin
);
    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] quo, rem, dvs;
    logic [SW-1:0]    step;
    logic [WIDTH:0]   trial;

    // Shift the next dividend bit into the partial remainder and try a subtract.
    always_comb begin
        trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo  <= '0;
            rem  <= '0;
            dvs  <= '0;
            step <= '0;
        end else if (load) begin
            quo  <= dividend;
            rem  <= '0;
            dvs  <= divisor;
            step <= '0;
        end else if (run) begin
            if (!trial[WIDTH]) begin
                rem <= trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
            step <= step + 1'b1;
        end
    end

    assign fin       = run && (step == SW'(WIDTH - 1));
    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MADD/MSUB/DIV unit with start/done handshake and flush.
// Define MULDIV_EARLY_OUT_EN to short-circuit divisions where |divisor| > |dividend|.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    input  logic [2*WIDTH-1:0] hilo_i,
    input  logic               cancel_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] res_o,
    output logic               div_by_zero_o
);
    localparam int MSTG = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
    localparam int TAP  = (MUL_LAT > 2) ? MUL_LAT - 3 : 0;

    state_t             state, state_nxt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] hilo_q, res_q;
    logic               dbz_q, early_q;

    logic               accept, in_div, in_bz, early_in;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;

    assign accept   = start_i && !cancel_i && (state == ST_IDLE || state == ST_DONE);
    assign in_div   = is_div(op_i);
    assign in_bz    = (opb_i == '0);
    assign mag_a_in = (is_signed(op_i) && opa_i[WIDTH-1]) ? -opa_i : opa_i;
    assign mag_b_in = (is_signed(op_i) && opb_i[WIDTH-1]) ? -opb_i : opb_i;

`ifdef MULDIV_EARLY_OUT_EN
    assign early_in = (mag_b_in > mag_a_in);
`else
    assign early_in = 1'b0;
`endif

    // Multiplier: with a single-cycle latency the product is formed straight from the inputs.
    logic [2:0]         m_op;
    logic [WIDTH-1:0]   m_a, m_b, m_ma, m_mb;
    logic [2*WIDTH-1:0] m_h, m_pu, m_p, mul_res, mul_out;
    logic [2*WIDTH-1:0] mul_stg [0:TAP];
    logic [MSTG:0]      vld_pipe;

    always_comb begin
        m_op = (MUL_LAT == 1) ? op_i   : op_q;
        m_a  = (MUL_LAT == 1) ? opa_i  : a_q;
        m_b  = (MUL_LAT == 1) ? opb_i  : b_q;
        m_h  = (MUL_LAT == 1) ? hilo_i : hilo_q;
        m_ma = (is_signed(m_op) && m_a[WIDTH-1]) ? -m_a : m_a;
        m_mb = (is_signed(m_op) && m_b[WIDTH-1]) ? -m_b : m_b;
        m_pu = {{WIDTH{1'b0}}, m_ma} * {{WIDTH{1'b0}}, m_mb};
        m_p  = (is_signed(m_op) && (m_a[WIDTH-1] ^ m_b[WIDTH-1])) ? -m_pu : m_pu;
        if (!is_acc(m_op))
            mul_res = m_p;
        else if (m_op == OP_MADD || m_op == OP_MADDU)
            mul_res = m_h + m_p;
        else
            mul_res = m_h - m_p;
        mul_out = (MUL_LAT > 2) ? mul_stg[TAP] : mul_res;
    end

    always_ff @(posedge clk) begin
        mul_stg[0] <= mul_res;
        for (int i = 1; i <= TAP; i++)
            mul_stg[i] <= mul_stg[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst || cancel_i) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= accept && !in_div;
            for (int i = 1; i <= MSTG; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Divider plus sign fix-up: quotient sign is sa^sb, remainder follows the dividend.
    logic [WIDTH-1:0]   quo, rem, q_s, r_s;
    logic               div_fin;
    logic [2*WIDTH-1:0] div_res;

    div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && in_div),
        .run       (state == ST_DIV),
        .dividend  (mag_a_in),
        .divisor   (mag_b_in),
        .quotient  (quo),
        .remainder (rem),
        .fin       (div_fin)
    );

    always_comb begin
        q_s     = (is_signed(op_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo : quo;
        r_s     = (is_signed(op_q) && a_q[WIDTH-1]) ? -rem : rem;
        div_res = early_q ? {a_q, {WIDTH{1'b0}}} : {r_s, q_s};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (in_div)
                        state_nxt = in_bz ? ST_DONE : (early_in ? ST_FIX : ST_DIV);
                    else
                        state_nxt = (MUL_LAT == 1) ? ST_DONE : ST_MUL;
                end
            end
            ST_MUL:  if (cancel_i) state_nxt = ST_IDLE;
                     else if (vld_pipe[MSTG]) state_nxt = ST_DONE;
            ST_DIV:  if (cancel_i) state_nxt = ST_IDLE;
                     else if (div_fin) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = cancel_i ? ST_IDLE : ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // res_q only moves on the edge that enters DONE, so it holds across flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hilo_q  <= '0;
            res_q   <= '0;
            dbz_q   <= 1'b0;
            early_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= op_i;
                a_q     <= opa_i;
                b_q     <= opb_i;
                hilo_q  <= hilo_i;
                early_q <= in_div && !in_bz && early_in;
                dbz_q   <= in_div && in_bz;
                if (in_div && in_bz)
                    res_q <= {opa_i, {WIDTH{1'b1}}};
                else if (MUL_LAT == 1 && !in_div)
                    res_q <= mul_res;
            end
            if (state == ST_MUL && !cancel_i && vld_pipe[MSTG])
                res_q <= mul_out;
            if (state == ST_FIX && !cancel_i)
                res_q <= div_res;
        end
    end

    assign busy_o        = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
    assign done_o        = (state == ST_DONE);
    assign res_o         = res_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH=32, MUL_LAT=2).
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst, start_i, cancel_i;
    logic [2:0]  op_i;
    logic [31:0] opa_i, opb_i;
    logic [63:0] hilo_i;
    logic        busy_o, done_o, div_by_zero_o;
    logic [63:0] res_o;

    int n_vec = 0;
    int n_err = 0;
    int lat, dones;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .MUL_LAT(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .op_i          (op_i),
        .opa_i         (opa_i),
        .opb_i         (opb_i),
        .hilo_i        (hilo_i),
        .cancel_i      (cancel_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .res_o         (res_o),
        .div_by_zero_o (div_by_zero_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present an op at the current point (a negedge); start is sampled at the next posedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] h);
        op_i = op; opa_i = a; opb_i = b; hilo_i = h; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    // Latency in cycles after the sampling edge until done_o is seen; -1 on timeout.
    task automatic wait_done(output int l);
        l = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (done_o) begin
                l = n;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] h, output int l);
        @(negedge clk);
        issue(op, a, b, h);
        wait_done(l);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0;
        op_i = '0; opa_i = '0; opb_i = '0; hilo_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_res",  res_o, 64'd0);
        chk("rst_dbz",  64'(div_by_zero_o), 64'd0);

        run_op(3'd0, 32'hFFFFFFFD, 32'd5, 64'd0, lat);
        chk("mult_lat", 64'(lat), 64'd2);
        chk("mult_res", res_o, 64'hFFFFFFFF_FFFFFFF1);
        @(negedge clk);
        chk("done_one_cycle", 64'(done_o), 64'd0);

        run_op(3'd1, 32'hFFFFFFFD, 32'd5, 64'd0, lat);
        chk("multu_res", res_o, 64'h00000004_FFFFFFF1);

        run_op(3'd3, 32'd1, 32'd1, 64'h00000000_FFFFFFFF, lat);
        chk("maddu_res", res_o, 64'h00000001_00000000);

        run_op(3'd4, 32'd2, 32'd3, 64'd0, lat);
        chk("msub_res", res_o, 64'hFFFFFFFF_FFFFFFFA);

        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 64'd0, lat);
        chk("div_lat", 64'(lat), 64'd34);
        chk("div_res", res_o, 64'hFFFFFFFF_FFFFFFFD);
        chk("div_dbz", 64'(div_by_zero_o), 64'd0);

        run_op(3'd7, 32'd7, 32'd0, 64'd0, lat);
        chk("dbz_lat", 64'(lat), 64'd1);
        chk("dbz_res", res_o, 64'h00000007_FFFFFFFF);
        chk("dbz_flag", 64'(div_by_zero_o), 64'd1);

        // Flush a division at cycle k+10, then launch a multiply at k+11.
        @(negedge clk);
        issue(3'd6, 32'd100, 32'd7, 64'd0);
        dones = 0;
        @(negedge clk);
        chk("dbz_clear", 64'(div_by_zero_o), 64'd0);
        chk("cancel_busy_run", 64'(busy_o), 64'd1);
        repeat (9) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        cancel_i = 1'b1;
        @(posedge clk);
        #1 cancel_i = 1'b0;
        @(negedge clk);
        chk("cancel_busy", 64'(busy_o), 64'd0);
        chk("cancel_done", 64'(done_o), 64'd0);
        chk("cancel_res",  res_o, 64'h00000007_FFFFFFFF);
        chk("cancel_nodone", 64'(dones), 64'd0);
        issue(3'd0, 32'hFFFFFFFE, 32'hFFFFFFFC, 64'd0);
        wait_done(lat);
        chk("post_cancel_lat", 64'(lat), 64'd2);
        chk("post_cancel_res", res_o, 64'd8);

        // A second start at k+5 with other operands must be ignored.
        @(negedge clk);
        issue(3'd6, 32'd100, 32'd7, 64'd0);
        repeat (5) @(negedge clk);
        op_i = 3'd7; opa_i = 32'd1000; opb_i = 32'd3; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        wait_done(lat);
        chk("ignore_lat", 64'(lat), 64'd29);
        chk("ignore_res", res_o, 64'h00000002_0000000E);

        // Back-to-back: next op issued in the DONE cycle.
        run_op(3'd6, 32'd7, 32'hFFFFFFFE, 64'd0, lat);
        chk("div_negb_res", res_o, 64'h00000001_FFFFFFFD);
        issue(3'd1, 32'd6, 32'd7, 64'd0);
        wait_done(lat);
        chk("b2b_lat", 64'(lat), 64'd2);
        chk("b2b_res", res_o, 64'd42);

        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 64'd0, lat);
        chk("div_ovf_res", res_o, 64'h00000000_80000000);

        run_op(3'd7, 32'd3, 32'd10, 64'd0, lat);
`ifdef MULDIV_EARLY_OUT_EN
        chk("early_lat", 64'(lat), 64'd2);
`else
        chk("early_lat", 64'(lat), 64'd34);
`endif
        chk("early_res", res_o, 64'h00000003_00000000);

        // Cancel together with start in IDLE launches nothing.
        @(negedge clk);
        @(negedge clk);
        op_i = 3'd0; opa_i = 32'd9; opb_i = 32'd9; start_i = 1'b1; cancel_i = 1'b1;
        @(posedge clk);
        #1 begin start_i = 1'b0; cancel_i = 1'b0; end
        @(negedge clk);
        chk("cancel_start_busy", 64'(busy_o), 64'd0);
        chk("cancel_start_done", 64'(done_o), 64'd0);
        @(negedge clk);
        chk("cancel_start_res", res_o, 64'h00000003_00000000);

        // Reset mid-division.
        issue(3'd6, 32'd100, 32'd7, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_done", 64'(done_o), 64'd0);
        chk("midrst_res",  res_o, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
